// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_e;

    // RISC-V load/store size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Per-byte write-enable masks, lanes relative to mem_address
    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_B    = 4'b0001;
    localparam logic [3:0] WEN_H    = 4'b0011;
    localparam logic [3:0] WEN_W    = 4'b1111;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
    } lsu_req_t;

    function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return WEN_B;
            2'b01:   return WEN_H;
            default: return WEN_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational sign/zero extension of raw SRAM read data for loads.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: IDLE -> ACCESS (one SRAM cycle) -> RESP.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [3:0]        mem_w_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e  state, state_nxt;
    lsu_req_t    lat;
    logic        accept, addr_oor, f3_bad, misalign, req_bad;
    logic [31:0] load_data;

    assign accept   = req_valid && (state == ST_IDLE);
    assign addr_oor = (req_addr >> ADDR_W) != 32'd0;
    assign f3_bad   = !funct3_ok(req_we, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_bad = addr_oor || f3_bad || misalign;

    lsu_load_ext u_load_ext (
        .funct3 (lat.funct3),
        .raw    (mem_read_data),
        .ext    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Write enables decode straight from state so reset drops them at once.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_w_en   = WEN_NONE;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = req_bad ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (lat.we)
                    mem_w_en = store_mask(lat.funct3);
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // SRAM address/data only move on a good accept, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat            <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
        end else begin
            if (accept) begin
                if (req_bad) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end else begin
                    lat.we         <= req_we;
                    lat.funct3     <= req_funct3;
                    mem_address    <= req_addr[ADDR_W-1:0];
                    mem_write_data <= req_wdata;
                    resp_err       <= 1'b0;
                end
            end
            if (state == ST_ACCESS)
                resp_rdata <= lat.we ? 32'd0 : load_data;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-wide wrapping SRAM model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  mem_w_en;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data, mem_read_data;

    logic [7:0]  mem [0:65535];
    logic        mem_clr;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_w_en       (mem_w_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Byte lane i lives at mem_address+i, wrapping modulo 64 KiB.
    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 4; i++)
            mem_read_data[8*i +: 8] = mem[mem_address + 16'(i)];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int j = 0; j < 65536; j++) mem[j] = 8'h00;
        end else begin
            for (int k = 0; k < 4; k++)
                if (mem_w_en[k]) mem[mem_address + 16'(k)] = mem_write_data[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; a junk store to 0x200 is held on req_valid while busy.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input logic [3:0] exp_wen,
                        input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = $urandom;
        if (exp_err) begin
            chk({tag, ".rv"},   {31'd0, resp_valid}, 32'd1);
            chk({tag, ".err"},  {31'd0, resp_err},   32'd1);
            chk({tag, ".rd"},   resp_rdata,          32'd0);
            chk({tag, ".wen"},  {28'd0, mem_w_en},   32'd0);
        end else begin
            chk({tag, ".rv0"},  {31'd0, resp_valid}, 32'd0);
            chk({tag, ".wen"},  {28'd0, mem_w_en},   {28'd0, exp_wen});
            chk({tag, ".addr"}, {16'd0, mem_address}, {16'd0, addr[15:0]});
            chk({tag, ".wd"},   mem_write_data,      wd);
            @(posedge clk); #1;
            chk({tag, ".rv"},   {31'd0, resp_valid}, 32'd1);
            chk({tag, ".err"},  {31'd0, resp_err},   32'd0);
            chk({tag, ".rd"},   resp_rdata,          exp_rd);
            chk({tag, ".wen0"}, {28'd0, mem_w_en},   32'd0);
        end
        @(posedge clk); #1;
        chk({tag, ".done"}, {30'd0, resp_valid, req_ready}, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        #1;
        chk("rst.ready", {31'd0, req_ready},  32'd1);
        chk("rst.rv",    {31'd0, resp_valid}, 32'd0);
        chk("rst.err",   {31'd0, resp_err},   32'd0);
        chk("rst.rd",    resp_rdata,          32'd0);
        chk("rst.wen",   {28'd0, mem_w_en},   32'd0);
        chk("rst.addr",  {16'd0, mem_address}, 32'd0);
        chk("rst.wd",    mem_write_data,      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; mem_clr = 1'b0;

        xact(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        4'b1111, "sw100");
        xact(1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, "lw100");
        xact(1'b0, 3'b000, 32'h103, 32'h0,        1'b0, 32'hFFFFFFDE, 4'b0000, "lb103");
        xact(1'b0, 3'b100, 32'h103, 32'h0,        1'b0, 32'h000000DE, 4'b0000, "lbu103");
        xact(1'b0, 3'b001, 32'h100, 32'h0,        1'b0, 32'hFFFFBEEF, 4'b0000, "lh100");
        xact(1'b0, 3'b101, 32'h102, 32'h0,        1'b0, 32'h0000DEAD, 4'b0000, "lhu102");

        xact(1'b0, 3'b010, 32'h0001_0000, 32'h0,  1'b1, 32'h0, 4'b0000, "lw_oor");
        xact(1'b1, 3'b000, 32'h8000_0000, 32'h5,  1'b1, 32'h0, 4'b0000, "sb_oor");
        xact(1'b0, 3'b011, 32'h100, 32'h0,        1'b1, 32'h0, 4'b0000, "ld_f3_011");
        xact(1'b0, 3'b111, 32'h100, 32'h0,        1'b1, 32'h0, 4'b0000, "ld_f3_111");
        xact(1'b1, 3'b100, 32'h100, 32'h0,        1'b1, 32'h0, 4'b0000, "st_f3_100");

        xact(1'b1, 3'b010, 32'hFFFE, 32'h11223344, 1'b0, 32'h0, 4'b1111, "sw_wrap");
        chk("wrap.fffe", {24'd0, mem[16'hFFFE]}, 32'h44);
        chk("wrap.ffff", {24'd0, mem[16'hFFFF]}, 32'h33);
        chk("wrap.0000", {24'd0, mem[16'h0000]}, 32'h22);
        chk("wrap.0001", {24'd0, mem[16'h0001]}, 32'h11);
        xact(1'b0, 3'b010, 32'hFFFE, 32'h0, 1'b0, 32'h11223344, 4'b0000, "lw_wrap");
        xact(1'b0, 3'b100, 32'h0000, 32'h0, 1'b0, 32'h00000022, 4'b0000, "lbu_0000");

        xact(1'b1, 3'b000, 32'h104, 32'h000000AB, 1'b0, 32'h0, 4'b0001, "sb104");
        xact(1'b1, 3'b001, 32'h106, 32'h00001234, 1'b0, 32'h0, 4'b0011, "sh106");
        xact(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 32'h123400AB, 4'b0000, "lw104");

`ifdef LSU_MISALIGN_TRAP_EN
        xact(1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 32'h0, 4'b0000, "lh101");
`else
        xact(1'b0, 3'b001, 32'h101, 32'h0, 1'b0, 32'hFFFFADBE, 4'b0000, "lh101");
`endif

        // Reset while an SB is in its ACCESS cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h108; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid.wen", {28'd0, mem_w_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid.wen0",  {28'd0, mem_w_en},   32'd0);
        chk("mid.rv",    {31'd0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid.rv2",   {31'd0, resp_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid.ready", {31'd0, req_ready},  32'd1);
        chk("mid.rv3",   {31'd0, resp_valid}, 32'd0);
        chk("mid.mem",   {24'd0, mem[16'h0108]}, 32'd0);

        chk("junk.mem",  {mem[16'h0203], mem[16'h0202], mem[16'h0201], mem[16'h0200]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDR_W, 16, SRAM byte-address width; request address bits above ADDR_W-1 are out of range.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  core presents a load/store request.
REQ-005 Port: req_ready  output  1  block can accept a request.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  input  3  RISC-V size/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data, LSB-aligned.
REQ-010 Port: resp_valid  output  1  one-cycle response strobe.
REQ-011 Port: resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 Port: resp_err  output  1  request rejected, no memory access made.
REQ-013 Port: mem_w_en  output  4  per-byte write enables to SRAM.
REQ-014 Port: mem_address  output  ADDR_W  SRAM byte address.
REQ-015 Port: mem_write_data  output  32  SRAM write data.
REQ-016 Port: mem_read_data  input  32  SRAM combinational read data.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: req_valid&&req_ready at a rising edge latches we/funct3/addr/wdata; IDLE->ACCESS, or IDLE->RESP with error if invalid.
REQ-019 Invalid: req_addr[31:ADDR_W]!=0; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-020 ACCESS lasts exactly one cycle: mem_address = latched addr[ADDR_W-1:0], mem_write_data = latched wdata.
REQ-021 ACCESS store: mem_w_en = 0001 (SB), 0011 (SH), 1111 (SW); load: mem_w_en = 0000.
REQ-022 Outside ACCESS, mem_w_en SHALL be 0000; mem_address/mem_write_data hold last value.
REQ-023 Load data captured from mem_read_data at the rising edge ending ACCESS: LB/LH sign-extend byte0/bytes1:0, LBU/LHU zero-extend, LW unchanged.
REQ-024 RESP: resp_valid=1 for exactly one cycle with registered resp_rdata/resp_err, then IDLE.
REQ-025 Latency: request accepted at edge N -> resp_valid high in cycle N+2 (valid) or N+1 (error); max throughput one request per 3 cycles.
REQ-026 Wrap: access at 0xFFFE/0xFFFF SHALL proceed, byte lanes wrapping to 0x0000 modulo 2^ADDR_W, no error.
REQ-027 req_valid while not ready is ignored; request fields may change freely outside the handshake edge.

Reset
REQ-028 rst_n low SHALL force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_w_en=0000, mem_address=0, mem_write_data=0.
REQ-029 Reset mid-ACCESS or mid-RESP drops the in-flight request with no response; mem_w_en deasserts asynchronously.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]!=0 or LW/SW with addr[1:0]!=0 is invalid (REQ-018 error path).
REQ-031 Macro undefined: misaligned accesses proceed as ordinary byte-lane accesses at the given address.

Structure
REQ-032 Package lsu_pkg SHALL hold the state enum, funct3 constants, and w_en mask constants.
REQ-033 One combinational sub-module lsu_load_ext SHALL perform load sign/zero extension.

Verification
REQ-034 SW addr 0x100 data 0xDEADBEEF -> one ACCESS cycle, mem_w_en=1111; then LW 0x100 -> resp_rdata=0xDEADBEEF two cycles after accept.
REQ-035 After REQ-034: LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x100 -> 0xFFFFBEEF; LHU 0x102 -> 0x0000DEAD.
REQ-036 LW addr 0x0001_0000 -> resp_err=1, resp_rdata=0, mem_w_en never nonzero, resp one cycle after accept.
REQ-037 SW 0xFFFE data 0x11223344 -> bytes 0xFFFE=44, 0xFFFF=33, 0x0000=22, 0x0001=11.
REQ-038 LH 0x101: with LSU_MISALIGN_TRAP_EN -> resp_err=1; without -> data from bytes 0x102:0x101, no error.
REQ-039 rst_n low during ACCESS of SB -> mem_w_en=0 immediately, no resp_valid; req_ready=1 after release.
